io_input_cond: RTL and testbench

//   Input-side conditioning for the memory-mapped I/O window. Takes raw board switches and push-buttons,

---
 rtl/io_input_cond.sv | 168 ++++++++++++++++
 tb/tb_io_input_cond.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_input_cond.sv
// ----------------------------------------------------------------------------
// io_input_cond
//
// Input-side conditioning for the memory-mapped I/O window. Raw board switches
// and push-buttons are synchronised into clk_i, buttons are debounced and
// press events are recorded in sticky flags that the CPU clears with
// write-1-to-clear pulses. One instance per core, between pins and core top.
//
// Build option:
//   IO_SW_DEBOUNCE_EN  when defined, switches also pass through a debouncer
//                      (one counter per switch). Switches never raise events.
//                      When undefined, switches are only synchronised.
//
// Ports:
//   clk_i      in   core clock
//   rst_ni     in   asynchronous reset, active-low
//   sw_raw_i   in   [SW_W]  raw switch pins (asynchronous)
//   btn_raw_i  in   [BTN_W] raw button pins (asynchronous)
//   evt_clr_i  in   [BTN_W] write-1-to-clear pulse per event flag
//   io_sw_o    out  [32]    conditioned switches, zero-extended
//   io_btn_o   out  [BTN_W] debounced button level, 1 = pressed
//   btn_evt_o  out  [BTN_W] sticky press-event flags
//
// Debounce FSM (one per conditioned input):
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   DB_LOW   | accepted level is 0; counter tracks how long the input is 1
//   DB_HIGH  | accepted level is 1; counter tracks how long the input is 0
// ----------------------------------------------------------------------------
module io_input_cond #(
    parameter int unsigned SW_W           = 10,
    parameter int unsigned BTN_W          = 4,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned DB_CYCLES      = 500000,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [SW_W-1:0]  sw_raw_i,
    input  logic [BTN_W-1:0] btn_raw_i,
    input  logic [BTN_W-1:0] evt_clr_i,
    output logic [31:0]      io_sw_o,
    output logic [BTN_W-1:0] io_btn_o,
    output logic [BTN_W-1:0] btn_evt_o
);

    localparam int unsigned      CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    // Idle (released) pin level; also used to invert active-low buttons.
    localparam logic [BTN_W-1:0] BTN_IDLE = BTN_ACTIVE_LOW ? '1 : '0;

    typedef enum logic {
        DB_LOW  = 1'b0,
        DB_HIGH = 1'b1
    } db_state_e;

    // ------------------------------------------------------------------------
    // Synchronisers. Button flops reset to the idle pin level so that leaving
    // reset never looks like a press.
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][BTN_W-1:0] btn_sync_q;
    logic [SYNC_STAGES-1:0][SW_W-1:0]  sw_sync_q;
    logic [BTN_W-1:0]                  btn_synced;
    logic [SW_W-1:0]                   sw_synced;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            btn_sync_q <= {SYNC_STAGES{BTN_IDLE}};
            sw_sync_q  <= '0;
        end else begin
            btn_sync_q[0] <= btn_raw_i;
            sw_sync_q[0]  <= sw_raw_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                btn_sync_q[i] <= btn_sync_q[i-1];
                sw_sync_q[i]  <= sw_sync_q[i-1];
            end
        end
    end

    // XOR with the idle level turns the pin value into 1 = pressed.
    assign btn_synced = btn_sync_q[SYNC_STAGES-1] ^ BTN_IDLE;
    assign sw_synced  = sw_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Button debouncers. A new level is accepted on the DB_CYCLES-th
    // consecutive cycle it differs from the accepted one; any agreeing cycle
    // restarts the count, so the counter never wraps.
    // ------------------------------------------------------------------------
    logic [BTN_W-1:0] btn_press;

    for (genvar gi = 0; gi < BTN_W; gi++) begin : g_btn_db
        db_state_e        state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             level;

        assign level = (state_q == DB_HIGH);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= DB_LOW;
                cnt_q   <= '0;
            end else if (btn_synced[gi] == level) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                state_q <= db_state_e'(btn_synced[gi]);
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        // Asserted exactly in the cycle whose edge moves DB_LOW -> DB_HIGH.
        assign btn_press[gi] = (state_q == DB_LOW) && btn_synced[gi] && (cnt_q == CNT_LAST);
        assign io_btn_o[gi]  = level;
    end

    // ------------------------------------------------------------------------
    // Sticky press events: clear first, then set, so a press arriving with a
    // clear pulse on the same bit leaves the flag set.
    // ------------------------------------------------------------------------
    logic [BTN_W-1:0] evt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            evt_q <= '0;
        end else begin
            evt_q <= (evt_q & ~evt_clr_i) | btn_press;
        end
    end

    assign btn_evt_o = evt_q;

    // ------------------------------------------------------------------------
    // Switches
    // ------------------------------------------------------------------------
    logic [SW_W-1:0] sw_level;

`ifdef IO_SW_DEBOUNCE_EN
    for (genvar gs = 0; gs < SW_W; gs++) begin : g_sw_db
        db_state_e        state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             level;

        assign level = (state_q == DB_HIGH);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= DB_LOW;
                cnt_q   <= '0;
            end else if (sw_synced[gs] == level) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                state_q <= db_state_e'(sw_synced[gs]);
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign sw_level[gs] = level;
    end
`else
    assign sw_level = sw_synced;
`endif

    assign io_sw_o = 32'(sw_level);

endmodule

// File: tb/tb_io_input_cond.sv
module tb_io_input_cond;

    localparam int SW_W  = 10;
    localparam int BTN_W = 4;
    localparam int SYNC  = 2;
    localparam int DB    = 4;
`ifdef IO_SW_DEBOUNCE_EN
    localparam bit SW_DB = 1'b1;
`else
    localparam bit SW_DB = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic [SW_W-1:0]  sw_raw_i = '0;
    logic [BTN_W-1:0] btn_raw_i = 4'hF;
    logic [BTN_W-1:0] evt_clr_i = '0;
    logic [31:0]      io_sw_o;
    logic [BTN_W-1:0] io_btn_o;
    logic [BTN_W-1:0] btn_evt_o;

    io_input_cond #(
        .SW_W(SW_W), .BTN_W(BTN_W), .SYNC_STAGES(SYNC),
        .DB_CYCLES(DB), .BTN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .sw_raw_i(sw_raw_i), .btn_raw_i(btn_raw_i),
        .evt_clr_i(evt_clr_i), .io_sw_o(io_sw_o), .io_btn_o(io_btn_o), .btn_evt_o(btn_evt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: an input's accepted level flips once the last DB
    // samples seen since the previous flip all disagree with it. Samples are
    // the raw pins delayed by SYNC clock edges.
    // ------------------------------------------------------------------
    typedef struct {
        logic        s;
        int          age;
        logic [31:0] hist;
    } chan_t;

    typedef struct {
        logic [BTN_W-1:0] btn;
        logic [BTN_W-1:0] evt;
        logic [31:0]      sw;
    } exp_t;

    function automatic chan_t db_step(chan_t c, logic smp);
        logic [31:0] mask;
        mask   = (32'd1 << DB) - 32'd1;
        c.hist = {c.hist[30:0], smp};
        c.age++;
        if (c.age >= DB && (c.hist & mask) == (c.s ? 32'd0 : mask)) begin
            c.s   = smp;
            c.age = 0;
        end
        return c;
    endfunction

    logic [BTN_W-1:0] btn_rawq[$];
    logic [SW_W-1:0]  sw_rawq[$];
    chan_t            m_btn[BTN_W];
    chan_t            m_sw[SW_W];
    logic [BTN_W-1:0] m_evt;
    exp_t             expq[$];

    always @(posedge clk_i) begin
        exp_t e;
        if (!rst_ni) begin
            btn_rawq = {};
            sw_rawq  = {};
            for (int i = 0; i < SYNC; i++) begin
                btn_rawq.push_back(4'hF);
                sw_rawq.push_back('0);
            end
            for (int b = 0; b < BTN_W; b++) m_btn[b] = '{s: 1'b0, age: 0, hist: 32'd0};
            for (int b = 0; b < SW_W; b++)  m_sw[b]  = '{s: 1'b0, age: 0, hist: 32'd0};
            m_evt = '0;
            e = '{btn: '0, evt: '0, sw: 32'd0};
        end else begin
            logic [BTN_W-1:0] bsmp;
            logic [SW_W-1:0]  ssmp;
            logic [BTN_W-1:0] press;
            logic [SW_W-1:0]  swv;
            bsmp  = ~btn_rawq[SYNC-1];
            ssmp  = sw_rawq[SYNC-1];
            press = '0;
            for (int b = 0; b < BTN_W; b++) begin
                logic old;
                old      = m_btn[b].s;
                m_btn[b] = db_step(m_btn[b], bsmp[b]);
                press[b] = !old && m_btn[b].s;
            end
            m_evt = (m_evt & ~evt_clr_i) | press;
            btn_rawq.push_front(btn_raw_i);
            void'(btn_rawq.pop_back());
            sw_rawq.push_front(sw_raw_i);
            void'(sw_rawq.pop_back());
            for (int b = 0; b < SW_W; b++) begin
                m_sw[b] = db_step(m_sw[b], ssmp[b]);
                swv[b]  = SW_DB ? m_sw[b].s : sw_rawq[SYNC-1][b];
            end
            for (int b = 0; b < BTN_W; b++) e.btn[b] = m_btn[b].s;
            e.evt = m_evt;
            e.sw  = 32'(swv);
        end
        expq.push_back(e);
    end

    // Monitor: compares the DUT outputs to the expectation of each edge.
    initial begin
        forever begin
            @(posedge clk_i);
            #2;
            if (expq.size() > 0) begin
                exp_t e;
                e = expq.pop_front();
                check("sb_btn", 32'(io_btn_o), 32'(e.btn));
                check("sb_evt", 32'(btn_evt_o), 32'(e.evt));
                check("sb_sw", io_sw_o, e.sw);
            end
        end
    end

    // Counts edges until io_btn_o[b] reaches want (bounded).
    task automatic wait_btn(input int b, input logic want, input int exp_cyc, input string nm);
        int n;
        n = 0;
        do begin
            @(posedge clk_i);
            #2;
            n++;
        end while (io_btn_o[b] !== want && n < 40);
        check(nm, 32'(n), 32'(exp_cyc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        // 1. reset and idle
        repeat (3) @(negedge clk_i);
        check("reset_btn", 32'(io_btn_o), 32'd0);
        check("reset_evt", 32'(btn_evt_o), 32'd0);
        check("reset_sw", io_sw_o, 32'd0);
        rst_ni = 1'b1;
        repeat (20) @(negedge clk_i);
        check("idle_btn", 32'(io_btn_o), 32'd0);
        check("idle_evt", 32'(btn_evt_o), 32'd0);

        // 2. press / release latency of button 0
        btn_raw_i[0] = 1'b0;
        wait_btn(0, 1'b1, SYNC + DB, "btn0_press_latency");
        check("btn0_evt_set", 32'(btn_evt_o[0]), 32'd1);
        repeat (3) @(negedge clk_i);
        btn_raw_i[0] = 1'b1;
        wait_btn(0, 1'b0, SYNC + DB, "btn0_release_latency");
        check("btn0_evt_sticky", 32'(btn_evt_o[0]), 32'd1);
        @(negedge clk_i);

        // 3. short glitch on button 1 is ignored
        btn_raw_i[1] = 1'b0;
        repeat (3) @(negedge clk_i);
        btn_raw_i[1] = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk_i);
            if (io_btn_o[1] || btn_evt_o[1]) seen = 1'b1;
        end
        check("btn1_glitch_ignored", 32'(seen), 32'd0);

        // 4. clear, then clear colliding with a new press
        btn_raw_i[2] = 1'b0;
        repeat (10) @(negedge clk_i);
        btn_raw_i[2] = 1'b1;
        repeat (10) @(negedge clk_i);
        check("btn2_evt_before_clr", 32'(btn_evt_o[2]), 32'd1);
        evt_clr_i = 4'b0100;
        @(negedge clk_i);
        evt_clr_i = 4'b0000;
        check("btn2_evt_cleared", 32'(btn_evt_o[2]), 32'd0);
        btn_raw_i[2] = 1'b0;
        repeat (SYNC + DB - 1) @(negedge clk_i);
        evt_clr_i = 4'b0100;
        @(negedge clk_i);
        evt_clr_i = 4'b0000;
        check("btn2_set_wins", 32'(btn_evt_o[2]), 32'd1);
        check("btn2_level", 32'(io_btn_o[2]), 32'd1);
        btn_raw_i[2] = 1'b1;
        repeat (10) @(negedge clk_i);

        // 5. switches: latency and glitch handling
        sw_raw_i = 10'h2A5;
        n = 0;
        do begin
            @(posedge clk_i);
            #2;
            n++;
        end while (io_sw_o !== 32'h0000_02A5 && n < 40);
        check("sw_latency", 32'(n), SW_DB ? 32'(SYNC + DB) : 32'(SYNC));
        @(negedge clk_i);
        repeat (8) @(negedge clk_i);
        sw_raw_i = 10'h2A4;
        repeat (2) @(negedge clk_i);
        sw_raw_i = 10'h2A5;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk_i);
            if (io_sw_o == 32'h0000_02A4) seen = 1'b1;
        end
        check("sw_glitch_passed", 32'(seen), SW_DB ? 32'd0 : 32'd1);

        // 6. reset mid-debounce discards the count
        btn_raw_i[3] = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        wait_btn(3, 1'b1, SYNC + DB, "btn3_after_reset_latency");
        check("btn3_fresh_evt", 32'(btn_evt_o[3]), 32'd1);
        @(negedge clk_i);
        btn_raw_i[3] = 1'b1;
        repeat (10) @(negedge clk_i);

        // 7. random traffic, slow enough that some presses are accepted
        repeat (400) begin
            @(negedge clk_i);
            for (int b = 0; b < BTN_W; b++)
                if ($urandom_range(0, 5) == 0) btn_raw_i[b] = ~btn_raw_i[b];
            if ($urandom_range(0, 7) == 0) sw_raw_i = SW_W'($urandom);
            evt_clr_i = ($urandom_range(0, 5) == 0) ? BTN_W'($urandom) : '0;
            if ($urandom_range(0, 199) == 0) rst_ni = 1'b0;
            else rst_ni = 1'b1;
        end
        rst_ni    = 1'b1;
        evt_clr_i = '0;
        repeat (5) @(negedge clk_i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
